// File: rtl/control_pipe.sv
// ID->EX control pipeline register: opcode decode, load-use interlock, flush,
// and a counter-timed EX occupancy for FP divide and square root.
module control_pipe #(
  parameter int unsigned DIV_LAT  = 8,
  parameter int unsigned SQRT_LAT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_id,
  input  logic [6:0]  opcode_id,
  input  logic [6:0]  funct7_id,
  input  logic [4:0]  rd_id,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        flush,
  output logic [10:0] ctrl_ex,
  output logic        valid_ex,
  output logic [4:0]  rd_ex,
  output logic        stall_id,
  output logic        fpu_busy,
  output logic        fpu_done
);

  localparam logic [6:0] OP_FP    = 7'b1010011;
  localparam logic [6:0] F7_DIV   = 7'b0001100;
  localparam logic [6:0] F7_SQRT  = 7'b0101100;
  localparam logic [7:0] DIV_CNT  = 8'(DIV_LAT - 1);
  localparam logic [7:0] SQRT_CNT = 8'(SQRT_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [7:0]  count, count_nxt;
  logic [10:0] word;
  logic        is_div, is_sqrt;
  logic        ex_int_dst, ex_fp_dst, rs1_hit, rs2_hit, hazard;
  logic        hold, bubble;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    word = '0;
    if (valid_id) begin
      unique case (opcode_id)
        7'b0010011: word = 11'h488;
        7'b0110011: word = 11'h088;
        7'b0000011: word = 11'h6C0;
        7'b0100011: word = 11'h420;
        7'b1100011: word = 11'h018;
        7'b0000111: word = 11'h740;
        7'b0100111: word = 11'h421;
        7'b1100111: word = 11'h098;
        7'b1101111: word = 11'h098;
        OP_FP: begin
          unique case (funct7_id)
            7'b0011000: word = 11'h08E;
            7'b0011100: word = 11'h10C;
            default:    word = 11'h10F;
          endcase
        end
        default:    word = '0;
      endcase
    end
  end

  assign is_div  = valid_id && (opcode_id == OP_FP) && (funct7_id == F7_DIV);
  assign is_sqrt = valid_id && (opcode_id == OP_FP) && (funct7_id == F7_SQRT);

  // x0 is hard-wired zero and never forwards a hazard; f0 is a real register.
  assign ex_int_dst = (ctrl_ex[8:7] == 2'b01) && (rd_ex != 5'd0);
  assign ex_fp_dst  = (ctrl_ex[8:7] == 2'b10);
  assign rs1_hit    = (rd_ex == rs1_id) && (word[1] ? ex_fp_dst : ex_int_dst);
  assign rs2_hit    = (rd_ex == rs2_id) && (word[0] ? ex_fp_dst : ex_int_dst);
  assign hazard     = (state == IDLE) && valid_id && valid_ex && ctrl_ex[6]
                      && (rs1_hit || rs2_hit);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    hold      = 1'b0;
    bubble    = 1'b0;
    unique case (state)
      IDLE: bubble = flush || hazard;
      BUSY: begin
        if (count != 8'd0) begin
          hold      = 1'b1;
          count_nxt = count - 8'd1;
        end
      end
      default: ;
    endcase
    if (!hold) begin
      if (!bubble && is_div) begin
        state_nxt = BUSY;
        count_nxt = DIV_CNT;
      end else if (!bubble && is_sqrt) begin
        state_nxt = BUSY;
        count_nxt = SQRT_CNT;
      end else begin
        state_nxt = IDLE;
        count_nxt = 8'd0;
      end
    end
  end

  assign fpu_busy = (state == BUSY);
  assign fpu_done = (state == BUSY) && (count == 8'd0);
  assign stall_id = !rst && ((state == BUSY) ? (count != 8'd0) : (hazard && !flush));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 8'd0;
      ctrl_ex  <= '0;
      valid_ex <= 1'b0;
      rd_ex    <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (!hold) begin
        ctrl_ex  <= bubble ? 11'h000 : word;
        valid_ex <= !bubble && valid_id;
        rd_ex    <= (bubble || !valid_id) ? 5'd0 : rd_id;
      end
    end
  end

endmodule
